// File: rtl/lv_efuse_load_ctrl.sv
// Efuse load responder: reads every efuse word in turn, mirrors it into the LV register bank,
// and reports completion and integrity. Optional macro: LV_EFUSE_XOR_CHK_EN (XOR checksum word).
module lv_efuse_load_ctrl #(
    parameter int EFUSE_WORDS = 8,
    parameter int EFUSE_DW    = 8,
    parameter int EFUSE_AW    = $clog2(EFUSE_WORDS),
    parameter int RD_WAIT_CYC = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_efuse_load_req,
    output logic                o_efuse_load_done,
    output logic                o_efuse_busy,
    output logic                o_efuse_rd_en,
    output logic [EFUSE_AW-1:0] o_efuse_addr,
    input  logic [EFUSE_DW-1:0] i_efuse_rdata,
    output logic                o_reg_wr_en,
    output logic [EFUSE_AW-1:0] o_reg_wr_addr,
    output logic [EFUSE_DW-1:0] o_reg_wr_data,
    output logic                o_efuse_chk_ok
);

    localparam int                 CNT_W     = (RD_WAIT_CYC > 1) ? $clog2(RD_WAIT_CYC) : 1;
    localparam logic [EFUSE_AW-1:0] LAST_ADDR = EFUSE_AW'(EFUSE_WORDS - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(RD_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAPT,
        S_GAP,
        S_DONE,
        S_HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [EFUSE_AW-1:0] addr_q,  addr_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [EFUSE_DW-1:0] data_q,  data_d;
    logic                chk_ok_q, chk_ok_d;
`ifdef LV_EFUSE_XOR_CHK_EN
    logic [EFUSE_DW-1:0] acc_q,   acc_d;
`endif

    // Every output is a decode of registered state, so the request never reaches an output combinationally.
    assign o_efuse_rd_en     = (state_q == S_RD);
    assign o_reg_wr_en       = (state_q == S_CAPT);
    assign o_efuse_load_done = (state_q == S_DONE);
    assign o_efuse_busy      = (state_q != S_IDLE) && (state_q != S_HOLD);
    assign o_efuse_addr      = addr_q;
    assign o_reg_wr_addr     = addr_q;
    assign o_reg_wr_data     = data_q;
    assign o_efuse_chk_ok    = chk_ok_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        chk_ok_d = chk_ok_q;
`ifdef LV_EFUSE_XOR_CHK_EN
        acc_d    = acc_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (i_efuse_load_req) begin
                    state_d  = S_RD;
                    addr_d   = '0;
                    cnt_d    = '0;
                    chk_ok_d = 1'b0;
`ifdef LV_EFUSE_XOR_CHK_EN
                    acc_d    = '0;
`endif
                end
            end

            S_RD: begin
                if (!i_efuse_load_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Macro data is settled after the full read wait; capture it for the write cycle.
                    state_d = S_CAPT;
                    data_d  = i_efuse_rdata;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_CAPT: begin
                if (!i_efuse_load_req) begin
                    state_d = S_IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    // Result must already be visible in the DONE cycle, so it is set on entry.
                    state_d  = S_DONE;
`ifdef LV_EFUSE_XOR_CHK_EN
                    chk_ok_d = (acc_q == data_q);
`else
                    chk_ok_d = 1'b1;
`endif
                end else begin
                    state_d = S_GAP;
`ifdef LV_EFUSE_XOR_CHK_EN
                    acc_d   = acc_q ^ data_q;
`endif
                end
            end

            S_GAP: begin
                if (!i_efuse_load_req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD;
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = '0;
                end
            end

            S_DONE: begin
                state_d = S_HOLD;
            end

            S_HOLD: begin
                if (!i_efuse_load_req) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the data register is reset too, because the write-data output it drives must read 0 out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            chk_ok_q <= 1'b0;
`ifdef LV_EFUSE_XOR_CHK_EN
            acc_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            chk_ok_q <= chk_ok_d;
`ifdef LV_EFUSE_XOR_CHK_EN
            acc_q    <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_lv_efuse_load_ctrl.sv
// Self-checking bench for lv_efuse_load_ctrl: a timing-formula model checked every cycle,
// plus literal expectations for the load timing, abort, hold and reset scenarios.
module tb_lv_efuse_load_ctrl;

    localparam int N      = 8;
    localparam int DW     = 8;
    localparam int AW     = 3;
    localparam int W      = 4;
    localparam int DONE_T = N * (W + 2) - 1;

`ifdef LV_EFUSE_XOR_CHK_EN
    localparam bit XOR_MODE = 1'b1;
`else
    localparam bit XOR_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          done, busy, rd_en, wr_en, chk_ok;
    logic [AW-1:0] efuse_addr, wr_addr;
    logic [DW-1:0] rdata, wr_data;
    logic [DW-1:0] mem [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Efuse macro model: a plain word array addressed by the DUT.
    assign rdata = mem[efuse_addr];

    lv_efuse_load_ctrl #(
        .EFUSE_WORDS (N),
        .EFUSE_DW    (DW),
        .EFUSE_AW    (AW),
        .RD_WAIT_CYC (W)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_efuse_load_req  (req),
        .o_efuse_load_done (done),
        .o_efuse_busy      (busy),
        .o_efuse_rd_en     (rd_en),
        .o_efuse_addr      (efuse_addr),
        .i_efuse_rdata     (rdata),
        .o_reg_wr_en       (wr_en),
        .o_reg_wr_addr     (wr_addr),
        .o_reg_wr_data     (wr_data),
        .o_efuse_chk_ok    (chk_ok)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a load is just a cycle index t from T0; outputs follow from t.
    typedef enum {M_IDLE, M_LOAD, M_HOLD} mode_e;
    mode_e m_mode = M_IDLE;
    int    m_t    = 0;
    bit    m_chk  = 1'b0;

    function automatic bit model_chk();
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < N - 1; i++) x ^= mem[i];
        return XOR_MODE ? (x == mem[N-1]) : 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE;
            m_t    <= 0;
            m_chk  <= 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (req) begin
                    m_mode <= M_LOAD;
                    m_t    <= 0;
                    m_chk  <= 1'b0;
                end
                M_LOAD: begin
                    if (m_t == DONE_T) m_mode <= M_HOLD;
                    else if (!req) m_mode <= M_IDLE;
                    else begin
                        m_t <= m_t + 1;
                        if (m_t + 1 == DONE_T) m_chk <= model_chk();
                    end
                end
                default: if (!req) m_mode <= M_IDLE;
            endcase
        end
    end

    task automatic compare_cycle();
        bit e_rd, e_wr, e_done, e_busy;
        int e_k;
        e_rd = 0; e_wr = 0; e_done = 0; e_busy = 0; e_k = 0;
        if (m_mode == M_LOAD) begin
            e_busy = 1;
            if (m_t == DONE_T) e_done = 1;
            else begin
                e_k  = m_t / (W + 2);
                e_rd = (m_t % (W + 2)) < W;
                e_wr = (m_t % (W + 2)) == W;
            end
        end
        check("cyc_rd_en", rd_en, e_rd);
        check("cyc_wr_en", wr_en, e_wr);
        check("cyc_done", done, e_done);
        check("cyc_busy", busy, e_busy);
        check("cyc_chk_ok", chk_ok, m_chk);
        if (e_rd) check("cyc_efuse_addr", efuse_addr, e_k);
        if (e_wr) begin
            check("cyc_wr_addr", wr_addr, e_k);
            check("cyc_wr_data", wr_data, mem[e_k]);
        end
    endtask

    always @(negedge clk) compare_cycle();

    // Event monitor: timing of reads, writes and done relative to T0.
    int cyc = 0;
    int t0 = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_t = -1, rd_last_t = -1;
    int wr_t [N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_en) begin
            rd_cnt    <= rd_cnt + 1;
            rd_last_t <= cyc - t0;
        end
        if (wr_en) begin
            if (wr_cnt < N) wr_t[wr_cnt] <= cyc - t0;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_t   <= cyc - t0;
        end
    end

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_t = -1; rd_last_t = -1;
        for (int i = 0; i < N; i++) wr_t[i] = -1;
    endtask

    task automatic load_mem(input logic [DW-1:0] last);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h44; mem[3] = 8'h88;
        mem[4] = 8'h01; mem[5] = 8'h02; mem[6] = 8'h04; mem[7] = last;
    endtask

    // Raises the request; returns at the negedge inside the T0 cycle.
    task automatic start_load();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        t0 = cyc;
    endtask

    // Returns at the negedge inside the done cycle, or flags a timeout.
    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", ok, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rd_en"}, rd_en, 1'b0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_chk_ok"}, chk_ok, 1'b0);
        check({tag, "_efuse_addr"}, efuse_addr, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        // XOR of 0x11,0x22,0x44,0x88,0x01,0x02,0x04 is 0xF8, the matching checksum word.
        load_mem(8'hF8);
        clear_stats();

        // Reset and a quiet idle period.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("reset");
        repeat (20) @(negedge clk);
        check("idle_rd_cnt", rd_cnt, 0);
        check("idle_wr_cnt", wr_cnt, 0);
        check("idle_done_cnt", done_cnt, 0);

        // Full load with a valid checksum; request dropped the cycle after done.
        clear_stats();
        start_load();
        wait_done();
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("good_done_t", done_t, 47);
        check("good_done_cnt", done_cnt, 1);
        check("good_wr_cnt", wr_cnt, 8);
        check("good_wr_t0", wr_t[0], 4);
        check("good_wr_t3", wr_t[3], 22);
        check("good_wr_t7", wr_t[7], 46);
        check("good_rd_cnt", rd_cnt, 32);
        check("good_chk_ok", chk_ok, 1'b1);
        check("good_busy", busy, 1'b0);

        // Corrupted checksum word.
        load_mem(8'hFE);
        clear_stats();
        start_load();
        wait_done();
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("bad_done_t", done_t, 47);
        check("bad_wr_cnt", wr_cnt, 8);
        check("bad_chk_ok", chk_ok, !XOR_MODE);

        // Abort during the word-3 read.
        load_mem(8'hF8);
        clear_stats();
        start_load();
        repeat (20) @(negedge clk);
        req = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_rd_last_t", rd_last_t, 20);
        check("abort_wr_cnt", wr_cnt, 3);
        check("abort_wr_t2", wr_t[2], 16);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_chk_ok", chk_ok, 1'b0);
        check("abort_busy", busy, 1'b0);

        // Request held after done never retriggers; re-raise in the IDLE-entry cycle.
        clear_stats();
        start_load();
        wait_done();
        repeat (10) @(negedge clk);
        check("hold_rd_cnt", rd_cnt, 32);
        check("hold_done_cnt", done_cnt, 1);
        check("hold_busy", busy, 1'b0);
        check("hold_chk_ok", chk_ok, 1'b1);
        mem[7] = 8'hFF;
        req = 1'b0;
        clear_stats();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        t0 = cyc;
        check("restart_chk_ok", chk_ok, 1'b0);
        check("restart_rd_en", rd_en, 1'b1);
        check("restart_busy", busy, 1'b1);
        wait_done();
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("restart_done_t", done_t, 47);
        check("restart_chk_ok_end", chk_ok, !XOR_MODE);

        // Asynchronous reset in the middle of a load, then a clean full load.
        mem[7] = 8'hF8;
        clear_stats();
        start_load();
        repeat (30) @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_stats();
        start_load();
        wait_done();
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("postreset_done_t", done_t, 47);
        check("postreset_wr_cnt", wr_cnt, 8);
        check("postreset_chk_ok", chk_ok, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
